mac_frame_accumulator: RTL

//   Downstream consumer of the multiply-add pipeline's DATA_OUT stream. It sums FRAME_LEN

---
 rtl/mac_frame_accumulator_if.sv | 24 ++
 rtl/mac_frame_accumulator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mac_frame_accumulator_if.sv
// rtl/mac_frame_accumulator_if.sv - sample input and frame-total output handshake bundle
interface mac_frame_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [ACC_WIDTH-1:0]  out_sum;
    logic                  out_ovf;
    logic                  out_valid;
    logic                  out_ready;

    // master: the environment feeding samples and consuming totals
    modport master (
        output in_data, in_valid, out_ready,
        input  out_sum, out_ovf, out_valid
    );

    // slave: the accumulator itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_sum, out_ovf, out_valid
    );
endinterface

// File: rtl/mac_frame_accumulator.sv
// rtl/mac_frame_accumulator.sv - sums FRAME_LEN samples into a saturating frame total
module mac_frame_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int FRAME_LEN  = 8,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    mac_frame_accumulator_if.slave bus,
    output logic                  busy,
    output logic [DROP_WIDTH-1:0] drop_cnt
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sat;
    logic [ACC_WIDTH-1:0] out_sum_r;
    logic                 out_ovf_r;
    logic                 out_valid_r;

    logic [ACC_WIDTH:0]   sum_ext;
    logic                 carry;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 last_sample;
    logic                 handshake;

    // One extra bit catches the carry out of the unsigned add.
    assign sum_ext     = {1'b0, acc} + {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, bus.in_data};
    assign carry       = sum_ext[ACC_WIDTH];
    assign sat_sum     = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    assign last_sample = (cnt == CNT_W'(FRAME_LEN - 1));
    assign handshake   = out_valid_r & bus.out_ready;

    assign bus.out_sum   = out_sum_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                if (start) begin
                    state_next = ACCUM;
                end else if (bus.in_valid && last_sample) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (handshake) state_next = start ? ACCUM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            drop_cnt    <= '0;
            out_sum_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        sat      <= 1'b0;
                        drop_cnt <= '0;
                    end
                end
                ACCUM: begin
                    // start wins: the same-cycle sample is thrown away
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        sat      <= 1'b0;
                        drop_cnt <= '0;
                    end else if (bus.in_valid) begin
                        acc <= sat_sum;
                        sat <= sat | carry;
                        cnt <= cnt + CNT_W'(1);
                        if (last_sample) begin
                            out_sum_r   <= sat_sum;
                            out_ovf_r   <= sat | carry;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.in_valid && (drop_cnt != {DROP_WIDTH{1'b1}})) begin
                        drop_cnt <= drop_cnt + DROP_WIDTH'(1);
                    end
                    if (handshake) begin
                        out_valid_r <= 1'b0;
                        // a restart clears the drop count even if a sample was dropped this cycle
                        if (start) begin
                            acc      <= '0;
                            cnt      <= '0;
                            sat      <= 1'b0;
                            drop_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
